// File: rtl/mac_arbiter_if.sv
// Bundle between the requester engines / MAC pipeline and mac_arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface mac_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  // Handshake: requester i holds req[i] with its operands stable; the operation
  // transfers in every cycle where req[i] & gnt[i]. Results return on rsp_valid
  // with no backpressure, so a requester must take rsp_data in that same cycle.
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_en;
  logic [NREQ*DW-1:0]     req_a;
  logic [NREQ*DW-1:0]     req_b;
  logic [NREQ*2*DW-1:0]   req_c;
  logic [NREQ-1:0]        gnt;
  logic [DW-1:0]          mac_a;
  logic [DW-1:0]          mac_b;
  logic [2*DW-1:0]        mac_c;
  logic                   mac_nop;
  logic [2*DW:0]          mac_p;
  logic [NREQ-1:0]        rsp_valid;
  logic [2*DW:0]          rsp_data;
  logic                   idle;

  modport master (
    output req, req_en, req_a, req_b, req_c, mac_p,
    input  gnt, mac_a, mac_b, mac_c, mac_nop, rsp_valid, rsp_data, idle
  );

  modport slave (
    input  req, req_en, req_a, req_b, req_c, mac_p,
    output gnt, mac_a, mac_b, mac_c, mac_nop, rsp_valid, rsp_data, idle
  );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin scheduler sharing one pipelined MAC among NREQ requesters, with a
// tag pipeline that routes each result back to its issuer and per-requester credit caps.
module mac_arbiter #(
  parameter int NREQ   = 4,
  parameter int DW     = 16,
  parameter int LAT    = 7,
  parameter int MAXOUT = 4
) (
  input  logic          clk,
  input  logic          aclr_n,
  mac_arbiter_if.slave  bus_if
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXOUT + 1);
  localparam int PW = 2 * DW + 1;

  logic [NREQ-1:0]  elig;
  logic             xfer;
  logic [IW-1:0]    sel;
  int               cand;
  logic [NREQ-1:0]  gnt;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q [NREQ];
  logic [CW-1:0]    cnt_d [NREQ];
  logic [NREQ-1:0]  inc_v, dec_v;

  logic [DW-1:0]    mac_a_q, mac_a_d;
  logic [DW-1:0]    mac_b_q, mac_b_d;
  logic [2*DW-1:0]  mac_c_q, mac_c_d;
  logic             mac_nop_q, mac_nop_d;

  logic             iss_v_q, iss_v_d;
  logic [IW-1:0]    iss_id_q, iss_id_d;
  logic [LAT-1:0]   tag_v_q;
  logic [IW-1:0]    tag_id_q [LAT];
  logic             tail_v;
  logic [IW-1:0]    tail_id;

  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]    rsp_data_q, rsp_data_d;
  logic             idle_q, idle_d;

  // Reset gates eligibility so gnt is zero while aclr_n is low.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus_if.req[i] & bus_if.req_en[i] & (cnt_q[i] < CW'(MAXOUT)) & aclr_n;
    end
  end

  always_comb begin
    xfer = 1'b0;
    sel  = '0;
    cand = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!xfer && elig[IW'(cand)]) begin
        xfer = 1'b1;
        sel  = IW'(cand);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = xfer && (sel == IW'(i));
    end
  end

  always_comb begin
    ptr_d     = xfer ? sel : ptr_q;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    mac_c_d   = mac_c_q;
    mac_nop_d = !xfer;
    iss_v_d   = xfer;
    iss_id_d  = sel;
    if (xfer) begin
      mac_a_d = bus_if.req_a[int'(sel)*DW +: DW];
      mac_b_d = bus_if.req_b[int'(sel)*DW +: DW];
      mac_c_d = bus_if.req_c[int'(sel)*2*DW +: 2*DW];
    end
  end

  // The issue register carries the tag during the mac_* cycle; LAT further
  // stages put the tail tag in the same cycle as the matching mac_p.
  assign tail_v  = tag_v_q[LAT-1];
  assign tail_id = tag_id_q[LAT-1];

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      inc_v[i] = xfer && (sel == IW'(i));
      dec_v[i] = tail_v && (tail_id == IW'(i));
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = tail_v && (tail_id == IW'(i));
    end
    if (tail_v) begin
      rsp_data_d = bus_if.mac_p;
    end
  end

  // Credit counters already cover issue, pipeline and the response cycle.
  always_comb begin
    idle_d = !xfer;
    for (int i = 0; i < NREQ; i++) begin
      if (cnt_q[i] != '0) begin
        idle_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ptr_q       <= IW'(NREQ - 1);
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
      mac_nop_q   <= 1'b1;
      iss_v_q     <= 1'b0;
      iss_id_q    <= '0;
      tag_v_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      idle_q      <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
      for (int k = 0; k < LAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
      mac_nop_q   <= mac_nop_d;
      iss_v_q     <= iss_v_d;
      iss_id_q    <= iss_id_d;
      tag_v_q     <= {tag_v_q[LAT-2:0], iss_v_q};
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      idle_q      <= idle_d;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      tag_id_q[0] <= iss_id_q;
      for (int k = 1; k < LAT; k++) begin
        tag_id_q[k] <= tag_id_q[k-1];
      end
    end
  end

  assign bus_if.gnt       = gnt;
  assign bus_if.mac_a     = mac_a_q;
  assign bus_if.mac_b     = mac_b_q;
  assign bus_if.mac_c     = mac_c_q;
  assign bus_if.mac_nop   = mac_nop_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_data  = rsp_data_q;
  assign bus_if.idle      = idle_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: a time-windowed transaction model of grants, credits
// and responses, driven by directed scenarios and a randomized run.
module tb_mac_arbiter;

  localparam int NREQ   = 4;
  localparam int DW     = 16;
  localparam int LAT    = 7;
  localparam int MAXOUT = 4;
  localparam int PW     = 2 * DW + 1;

  logic clk = 1'b0;
  logic aclr_n = 1'b0;
  always #5 clk = ~clk;

  mac_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus_if ();

  mac_arbiter #(.NREQ(NREQ), .DW(DW), .LAT(LAT), .MAXOUT(MAXOUT)) dut (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus_if (bus_if)
  );

  // Environment MAC: p = a*b + c, LAT cycles after the operands are presented.
  logic [PW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= PW'(bus_if.mac_a) * PW'(bus_if.mac_b) + PW'(bus_if.mac_c);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus_if.mac_p = pipe[LAT-1];

  typedef struct {
    int              id;
    int              t;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] c;
    logic [PW-1:0]   p;
  } op_t;

  op_t ops[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  ptr_m;
  int  exp_id;
  logic [NREQ-1:0] exp_gnt, exp_rsp_v;
  logic            exp_nop, exp_idle;
  logic [DW-1:0]   hold_a, hold_b;
  logic [2*DW-1:0] hold_c;
  logic [PW-1:0]   hold_p;

  task automatic model_reset();
    ops.delete();
    ptr_m  = NREQ - 1;
    hold_a = '0;
    hold_b = '0;
    hold_c = '0;
    hold_p = '0;
  endtask

  // An op granted in cycle t holds a credit in cycles t+1..t+LAT+1, is on the
  // MAC inputs in t+1 and is answered in t+LAT+2.
  task automatic model_eval();
    int cnt [NREQ];
    foreach (cnt[i]) cnt[i] = 0;
    exp_nop   = 1'b1;
    exp_rsp_v = '0;
    exp_idle  = 1'b1;
    foreach (ops[k]) begin
      if (cyc >= ops[k].t + 1 && cyc <= ops[k].t + LAT + 1) cnt[ops[k].id]++;
      if (ops[k].t == cyc - 1) begin
        exp_nop = 1'b0;
        hold_a  = ops[k].a;
        hold_b  = ops[k].b;
        hold_c  = ops[k].c;
      end
      if (ops[k].t == cyc - LAT - 2) begin
        exp_rsp_v[ops[k].id] = 1'b1;
        hold_p = ops[k].p;
      end
      if (ops[k].t >= cyc - LAT - 2 && ops[k].t <= cyc - 1) exp_idle = 1'b0;
    end
    exp_id  = -1;
    exp_gnt = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (ptr_m + k) % NREQ;
      if (exp_id < 0 && bus_if.req[j] && bus_if.req_en[j] && cnt[j] < MAXOUT) exp_id = j;
    end
    if (exp_id >= 0) exp_gnt[exp_id] = 1'b1;
  endtask

  task automatic model_commit();
    op_t o;
    if (exp_id >= 0) begin
      o.id = exp_id;
      o.t  = cyc;
      o.a  = bus_if.req_a[exp_id*DW +: DW];
      o.b  = bus_if.req_b[exp_id*DW +: DW];
      o.c  = bus_if.req_c[exp_id*2*DW +: 2*DW];
      o.p  = PW'(o.a) * PW'(o.b) + PW'(o.c);
      ops.push_back(o);
      ptr_m = exp_id;
    end
    while (ops.size() > 0 && ops[0].t < cyc - LAT - 2) void'(ops.pop_front());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input int a, input int b, input int c);
    bus_if.req_a[i*DW +: DW]     = DW'(a);
    bus_if.req_b[i*DW +: DW]     = DW'(b);
    bus_if.req_c[i*2*DW +: 2*DW] = (2*DW)'(c);
  endtask

  task automatic rand_operands();
    for (int i = 0; i < NREQ; i++) set_slot(i, int'($urandom), int'($urandom), int'($urandom));
  endtask

  // Called just after an active edge; releases reset before the next edge.
  task automatic do_reset();
    aclr_n = 1'b0;
    #2;
    aclr_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus_if.req    = '1;
    bus_if.req_en = '1;
    rand_operands();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus_if.gnt !== '0) $display("FAIL reset_gnt got=%b exp=0", bus_if.gnt); else n_pass++;
    n_chk++; if (bus_if.mac_nop !== 1'b1) $display("FAIL reset_nop got=%b exp=1", bus_if.mac_nop); else n_pass++;
    n_chk++; if ({bus_if.mac_a, bus_if.mac_b, bus_if.mac_c} !== '0) $display("FAIL reset_mac got=%h exp=0", {bus_if.mac_a, bus_if.mac_b, bus_if.mac_c}); else n_pass++;
    n_chk++; if (bus_if.rsp_valid !== '0) $display("FAIL reset_rsp_valid got=%b exp=0", bus_if.rsp_valid); else n_pass++;
    n_chk++; if (bus_if.rsp_data !== '0) $display("FAIL reset_rsp_data got=%h exp=0", bus_if.rsp_data); else n_pass++;
    n_chk++; if (bus_if.idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", bus_if.idle); else n_pass++;
    #2;
    aclr_n = 1'b1;
    model_reset();
    @(negedge clk);
    model_eval();
    n_chk++; if (bus_if.gnt !== 4'b0001) $display("FAIL reset_first_gnt got=%b exp=0001", bus_if.gnt); else n_pass++;
    model_commit();
    bus_if.req = '0;
  endtask

  task automatic test_single();
    do_reset();
    bus_if.req_en = '1;
    for (int k = 0; k < 12; k++) begin
      bus_if.req = (k == 0) ? NREQ'(1) : '0;
      if (k == 0) set_slot(0, 3, 4, 5);
      @(negedge clk);
      model_eval();
      n_chk++; if (bus_if.gnt !== exp_gnt) $display("FAIL single_gnt k=%0d got=%b exp=%b", k, bus_if.gnt, exp_gnt); else n_pass++;
      n_chk++; if (bus_if.mac_nop !== exp_nop) $display("FAIL single_nop k=%0d got=%b exp=%b", k, bus_if.mac_nop, exp_nop); else n_pass++;
      n_chk++; if (bus_if.rsp_valid !== exp_rsp_v) $display("FAIL single_rsp_valid k=%0d got=%b exp=%b", k, bus_if.rsp_valid, exp_rsp_v); else n_pass++;
      n_chk++; if (bus_if.idle !== exp_idle) $display("FAIL single_idle k=%0d got=%b exp=%b", k, bus_if.idle, exp_idle); else n_pass++;
      if (k == 0) begin
        n_chk++; if (bus_if.gnt !== 4'b0001) $display("FAIL single_gnt0 got=%b exp=0001", bus_if.gnt); else n_pass++;
      end
      if (k == 1) begin
        n_chk++; if ({bus_if.mac_nop, bus_if.mac_a, bus_if.mac_b} !== {1'b0, 16'd3, 16'd4}) $display("FAIL single_issue got=%b/%0d/%0d exp=0/3/4", bus_if.mac_nop, bus_if.mac_a, bus_if.mac_b); else n_pass++;
      end
      if (k == 9) begin
        n_chk++; if (bus_if.rsp_valid !== 4'b0001 || bus_if.rsp_data !== PW'(17)) $display("FAIL single_result got=%b/%0d exp=0001/17", bus_if.rsp_valid, bus_if.rsp_data); else n_pass++;
      end
      if (k == 10) begin
        n_chk++; if (bus_if.idle !== 1'b1) $display("FAIL single_idle_after got=%b exp=1", bus_if.idle); else n_pass++;
      end
      model_commit();
    end
  endtask

  task automatic test_fairness();
    do_reset();
    bus_if.req_en = '1;
    for (int k = 0; k < 20; k++) begin
      bus_if.req = (k < 8) ? '1 : '0;
      rand_operands();
      @(negedge clk);
      model_eval();
      n_chk++; if (bus_if.gnt !== exp_gnt) $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, bus_if.gnt, exp_gnt); else n_pass++;
      n_chk++; if (bus_if.rsp_valid !== exp_rsp_v || bus_if.rsp_data !== hold_p) $display("FAIL rr_rsp k=%0d got=%b/%h exp=%b/%h", k, bus_if.rsp_valid, bus_if.rsp_data, exp_rsp_v, hold_p); else n_pass++;
      if (k < 8) begin
        n_chk++; if (bus_if.gnt !== NREQ'(1 << (k % NREQ))) $display("FAIL rr_order k=%0d got=%b", k, bus_if.gnt); else n_pass++;
      end
      if (k >= 9 && k < 17) begin
        n_chk++; if (bus_if.rsp_valid !== NREQ'(1 << ((k - 9) % NREQ))) $display("FAIL rr_rsp_order k=%0d got=%b", k, bus_if.rsp_valid); else n_pass++;
      end
      model_commit();
    end
  endtask

  task automatic test_credit();
    do_reset();
    bus_if.req_en = '1;
    bus_if.req    = 4'b0100;
    for (int k = 0; k < 22; k++) begin
      rand_operands();
      @(negedge clk);
      model_eval();
      n_chk++; if (bus_if.gnt !== exp_gnt) $display("FAIL credit_gnt k=%0d got=%b exp=%b", k, bus_if.gnt, exp_gnt); else n_pass++;
      n_chk++; if (bus_if.gnt !== (((k % 9) < 4) ? 4'b0100 : 4'b0000)) $display("FAIL credit_pattern k=%0d got=%b", k, bus_if.gnt); else n_pass++;
      n_chk++; if (bus_if.rsp_valid !== exp_rsp_v) $display("FAIL credit_rsp k=%0d got=%b exp=%b", k, bus_if.rsp_valid, exp_rsp_v); else n_pass++;
      model_commit();
    end
    bus_if.req = '0;
  endtask

  task automatic test_mask();
    int seen1;
    seen1 = 0;
    do_reset();
    bus_if.req    = 4'b1011;
    bus_if.req_en = 4'b1001;
    for (int k = 0; k < 20; k++) begin
      if (k == 8) bus_if.req_en = 4'b1011;
      rand_operands();
      @(negedge clk);
      model_eval();
      n_chk++; if (bus_if.gnt !== exp_gnt) $display("FAIL mask_gnt k=%0d got=%b exp=%b", k, bus_if.gnt, exp_gnt); else n_pass++;
      if (k < 8) begin
        n_chk++; if (bus_if.gnt !== ((k % 2 == 1) ? 4'b1000 : 4'b0001)) $display("FAIL mask_alt k=%0d got=%b", k, bus_if.gnt); else n_pass++;
      end
      if (bus_if.gnt[1] === 1'b1) seen1++;
      model_commit();
    end
    n_chk++; if (seen1 == 0) $display("FAIL mask_enable got=0 grants to 1 exp=nonzero"); else n_pass++;
    bus_if.req    = '0;
    bus_if.req_en = '1;
  endtask

  task automatic test_nop();
    do_reset();
    bus_if.req_en = '1;
    for (int k = 0; k < 17; k++) begin
      bus_if.req = (k == 0 || k == 2 || k == 5) ? NREQ'(1) : '0;
      rand_operands();
      @(negedge clk);
      model_eval();
      n_chk++; if (bus_if.mac_nop !== exp_nop) $display("FAIL nop_model k=%0d got=%b exp=%b", k, bus_if.mac_nop, exp_nop); else n_pass++;
      n_chk++; if (bus_if.mac_nop !== !(k == 1 || k == 3 || k == 6)) $display("FAIL nop_pattern k=%0d got=%b", k, bus_if.mac_nop); else n_pass++;
      n_chk++; if (bus_if.rsp_valid !== ((k == 9 || k == 11 || k == 14) ? 4'b0001 : 4'b0000)) $display("FAIL nop_rsp k=%0d got=%b", k, bus_if.rsp_valid); else n_pass++;
      n_chk++; if (bus_if.rsp_data !== hold_p) $display("FAIL nop_rsp_data k=%0d got=%h exp=%h", k, bus_if.rsp_data, hold_p); else n_pass++;
      model_commit();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      bus_if.req    = NREQ'($urandom) | NREQ'($urandom);
      bus_if.req_en = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '1;
      rand_operands();
      @(negedge clk);
      model_eval();
      n_chk++; if (bus_if.gnt !== exp_gnt) $display("FAIL rand_gnt k=%0d got=%b exp=%b", k, bus_if.gnt, exp_gnt); else n_pass++;
      n_chk++; if (bus_if.mac_nop !== exp_nop) $display("FAIL rand_nop k=%0d got=%b exp=%b", k, bus_if.mac_nop, exp_nop); else n_pass++;
      n_chk++; if ({bus_if.mac_a, bus_if.mac_b, bus_if.mac_c} !== {hold_a, hold_b, hold_c}) $display("FAIL rand_mac k=%0d got=%h exp=%h", k, {bus_if.mac_a, bus_if.mac_b, bus_if.mac_c}, {hold_a, hold_b, hold_c}); else n_pass++;
      n_chk++; if (bus_if.rsp_valid !== exp_rsp_v) $display("FAIL rand_rsp_valid k=%0d got=%b exp=%b", k, bus_if.rsp_valid, exp_rsp_v); else n_pass++;
      n_chk++; if (bus_if.rsp_data !== hold_p) $display("FAIL rand_rsp_data k=%0d got=%h exp=%h", k, bus_if.rsp_data, hold_p); else n_pass++;
      n_chk++; if (bus_if.idle !== exp_idle) $display("FAIL rand_idle k=%0d got=%b exp=%b", k, bus_if.idle, exp_idle); else n_pass++;
      model_commit();
    end
    bus_if.req    = '0;
    bus_if.req_en = '1;
  endtask

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    do_reset();
    bus_if.req_en = '1;
    for (int k = 0; k < 5; k++) begin
      bus_if.req = (k < 3) ? 4'b0111 : 4'b0000;
      rand_operands();
      @(negedge clk);
      model_eval();
      n_chk++; if (bus_if.gnt !== exp_gnt) $display("FAIL arst_pre_gnt k=%0d got=%b exp=%b", k, bus_if.gnt, exp_gnt); else n_pass++;
      model_commit();
    end
    bus_if.req = '1;
    #1;
    aclr_n = 1'b0;
    #1;
    n_chk++; if (bus_if.gnt !== '0 || bus_if.mac_nop !== 1'b1 || bus_if.idle !== 1'b1) $display("FAIL arst_now got=%b/%b/%b exp=0000/1/1", bus_if.gnt, bus_if.mac_nop, bus_if.idle); else n_pass++;
    n_chk++; if (bus_if.rsp_valid !== '0 || bus_if.rsp_data !== '0 || bus_if.mac_a !== '0) $display("FAIL arst_regs got=%b/%h/%h exp=0/0/0", bus_if.rsp_valid, bus_if.rsp_data, bus_if.mac_a); else n_pass++;
    #1;
    aclr_n = 1'b1;
    model_reset();
    for (int k = 0; k < 14; k++) begin
      if (k > 0) bus_if.req = '0;
      @(negedge clk);
      model_eval();
      if (k == 0) begin
        n_chk++; if (bus_if.gnt !== 4'b0001) $display("FAIL arst_first_gnt got=%b exp=0001", bus_if.gnt); else n_pass++;
      end
      n_chk++; if (bus_if.rsp_valid !== exp_rsp_v) $display("FAIL arst_rsp k=%0d got=%b exp=%b", k, bus_if.rsp_valid, exp_rsp_v); else n_pass++;
      n_chk++; if (bus_if.idle !== exp_idle) $display("FAIL arst_idle k=%0d got=%b exp=%b", k, bus_if.idle, exp_idle); else n_pass++;
      if (bus_if.rsp_valid !== '0) pulses++;
      model_commit();
    end
    n_chk++; if (pulses != 1) $display("FAIL arst_rsp_count got=%0d exp=1", pulses); else n_pass++;
  endtask

  initial begin
    bus_if.req    = '0;
    bus_if.req_en = '1;
    bus_if.req_a  = '0;
    bus_if.req_b  = '0;
    bus_if.req_c  = '0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_credit();
    test_mask();
    test_nop();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
